// File: rtl/ingreso_datos.sv
// Front-panel data entry: BCD clock, date and timer fields
// edited from push buttons through a six-position field pointer.
module ingreso_datos (
  input  logic       clk,
  input  logic       reset,
  input  logic       C_T,
  input  logic       disminuye,
  input  logic       aumenta,
  input  logic       escribe,
  input  logic       corre_der,
  input  logic       corre_izq,
  input  logic       doce_24,
  output logic [7:0] seg_C,
  output logic [7:0] min_C,
  output logic [7:0] hora_C,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] ano,
  output logic [7:0] seg_T,
  output logic [7:0] min_T,
  output logic [7:0] hora_T
);

  typedef enum logic [2:0] {
    SEG  = 3'd0,
    MIN  = 3'd1,
    HORA = 3'd2,
    DIA  = 3'd3,
    MES  = 3'd4,
    ANO  = 3'd5
  } ptr_e;

  ptr_e ptr_q, ptr_d;

  logic der_q, der_d;
  logic izq_q, izq_d;

  logic [7:0] seg_c_q, seg_c_d;
  logic [7:0] min_c_q, min_c_d;
  logic [7:0] hora_c_q, hora_c_d;
  logic [7:0] dia_q, dia_d;
  logic [7:0] mes_q, mes_d;
  logic [7:0] ano_q, ano_d;
  logic [7:0] seg_t_q, seg_t_d;
  logic [7:0] min_t_q, min_t_d;
  logic [7:0] hora_t_q, hora_t_d;

  logic       der_edge;
  logic       izq_edge;
  logic       step;
  logic       up;
  logic [7:0] hc_lo;
  logic [7:0] hc_hi;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[7:4] = v[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r[7:4] = v[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Out-of-range values snap to the wrap target of the step direction.
  function automatic logic [7:0] bcd_step(
    input logic [7:0] v,
    input logic       inc,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    logic [7:0] r;
    if (inc) begin
      if (v >= hi || v < lo) r = lo;
      else                   r = bcd_inc(v);
    end else begin
      if (v <= lo || v > hi) r = hi;
      else                   r = bcd_dec(v);
    end
    return r;
  endfunction

  always_comb begin
    der_d    = corre_der;
    izq_d    = corre_izq;
    der_edge = corre_der & ~der_q;
    izq_edge = corre_izq & ~izq_q;

    ptr_d = ptr_q;
    if (escribe && (der_edge ^ izq_edge)) begin
      if (der_edge) begin
        unique case (ptr_q)
          SEG:     ptr_d = MIN;
          MIN:     ptr_d = HORA;
          HORA:    ptr_d = DIA;
          DIA:     ptr_d = MES;
          MES:     ptr_d = ANO;
          default: ptr_d = SEG;
        endcase
      end else begin
        unique case (ptr_q)
          SEG:     ptr_d = ANO;
          MIN:     ptr_d = SEG;
          HORA:    ptr_d = MIN;
          DIA:     ptr_d = HORA;
          MES:     ptr_d = DIA;
          default: ptr_d = MES;
        endcase
      end
    end
  end

  always_comb begin
    step  = escribe & (aumenta ^ disminuye);
    up    = aumenta;
    hc_lo = doce_24 ? 8'h01 : 8'h00;
    hc_hi = doce_24 ? 8'h12 : 8'h23;

    seg_c_d  = seg_c_q;
    min_c_d  = min_c_q;
    hora_c_d = hora_c_q;
    dia_d    = dia_q;
    mes_d    = mes_q;
    ano_d    = ano_q;
    seg_t_d  = seg_t_q;
    min_t_d  = min_t_q;
    hora_t_d = hora_t_q;

    // The step uses the pointer as it was before any move this cycle.
    if (step) begin
      unique case (ptr_q)
        SEG: begin
          if (C_T) seg_c_d = bcd_step(seg_c_q, up, 8'h00, 8'h59);
          else     seg_t_d = bcd_step(seg_t_q, up, 8'h00, 8'h59);
        end
        MIN: begin
          if (C_T) min_c_d = bcd_step(min_c_q, up, 8'h00, 8'h59);
          else     min_t_d = bcd_step(min_t_q, up, 8'h00, 8'h59);
        end
        HORA: begin
          if (C_T) hora_c_d = bcd_step(hora_c_q, up, hc_lo, hc_hi);
          else     hora_t_d = bcd_step(hora_t_q, up, 8'h00, 8'h23);
        end
        DIA:     dia_d = bcd_step(dia_q, up, 8'h01, 8'h31);
        MES:     mes_d = bcd_step(mes_q, up, 8'h01, 8'h12);
        ANO:     ano_d = bcd_step(ano_q, up, 8'h00, 8'h99);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= SEG;
      der_q    <= 1'b0;
      izq_q    <= 1'b0;
      seg_c_q  <= 8'h00;
      min_c_q  <= 8'h00;
      hora_c_q <= 8'h00;
      dia_q    <= 8'h01;
      mes_q    <= 8'h01;
      ano_q    <= 8'h00;
      seg_t_q  <= 8'h00;
      min_t_q  <= 8'h00;
      hora_t_q <= 8'h00;
    end else begin
      ptr_q    <= ptr_d;
      der_q    <= der_d;
      izq_q    <= izq_d;
      seg_c_q  <= seg_c_d;
      min_c_q  <= min_c_d;
      hora_c_q <= hora_c_d;
      dia_q    <= dia_d;
      mes_q    <= mes_d;
      ano_q    <= ano_d;
      seg_t_q  <= seg_t_d;
      min_t_q  <= min_t_d;
      hora_t_q <= hora_t_d;
    end
  end

  assign seg_C  = seg_c_q;
  assign min_C  = min_c_q;
  assign hora_C = hora_c_q;
  assign dia    = dia_q;
  assign mes    = mes_q;
  assign ano    = ano_q;
  assign seg_T  = seg_t_q;
  assign min_T  = min_t_q;
  assign hora_T = hora_t_q;

endmodule

// File: tb/tb_ingreso_datos.sv
// Directed vector bench for ingreso_datos; outputs are compared as
// {seg_C,min_C,hora_C,dia,mes,ano,seg_T,min_T,hora_T}.
module tb_ingreso_datos;

  logic       clk;
  logic       reset;
  logic       C_T;
  logic       disminuye;
  logic       aumenta;
  logic       escribe;
  logic       corre_der;
  logic       corre_izq;
  logic       doce_24;
  logic [7:0] seg_C, min_C, hora_C;
  logic [7:0] dia, mes, ano;
  logic [7:0] seg_T, min_T, hora_T;

  int total;
  int bad;

  ingreso_datos dut (
    .clk       (clk),
    .reset     (reset),
    .C_T       (C_T),
    .disminuye (disminuye),
    .aumenta   (aumenta),
    .escribe   (escribe),
    .corre_der (corre_der),
    .corre_izq (corre_izq),
    .doce_24   (doce_24),
    .seg_C     (seg_C),
    .min_C     (min_C),
    .hora_C    (hora_C),
    .dia       (dia),
    .mes       (mes),
    .ano       (ano),
    .seg_T     (seg_T),
    .min_T     (min_T),
    .hora_T    (hora_T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    bit          esc;
    bit          ct;
    bit          up;
    bit          dn;
    bit          der;
    bit          izq;
    bit          doce;
    int          reps;
    bit          chk;
    logic [71:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input string       n,
    input bit          rst,
    input bit          esc,
    input bit          ct,
    input bit          up,
    input bit          dn,
    input bit          der,
    input bit          izq,
    input bit          doce,
    input int          reps,
    input bit          chk,
    input logic [71:0] exp
  );
    vec_t v;
    v.name = n;
    v.rst  = rst;
    v.esc  = esc;
    v.ct   = ct;
    v.up   = up;
    v.dn   = dn;
    v.der  = der;
    v.izq  = izq;
    v.doce = doce;
    v.reps = reps;
    v.chk  = chk;
    v.exp  = exp;
    return v;
  endfunction

  function automatic logic [71:0] outs();
    return {seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T};
  endfunction

  task automatic check(input string n, input logic [71:0] exp);
    logic [71:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic drive(
    input bit rst, input bit esc, input bit ct, input bit up,
    input bit dn, input bit der, input bit izq, input bit doce,
    input int reps
  );
    reset     = rst;
    escribe   = esc;
    C_T       = ct;
    aumenta   = up;
    disminuye = dn;
    corre_der = der;
    corre_izq = izq;
    doce_24   = doce;
    repeat (reps) @(posedge clk);
    #1;
  endtask

  localparam logic [71:0] RST_V = 72'h00_00_00_01_01_00_00_00_00;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; escribe = 1'b0; C_T = 1'b0; aumenta = 1'b0;
    disminuye = 1'b0; corre_der = 1'b0; corre_izq = 1'b0;
    doce_24 = 1'b0;

    //          name            rst esc ct up dn dr iz 12 reps chk expected
    vq.push_back(mk("reset",         1,0,1,0,0,0,0,0, 1,1, RST_V));
    vq.push_back(mk("seg_c_wrap",    0,1,1,1,0,0,0,0,61,1, 72'h01_00_00_01_01_00_00_00_00));
    vq.push_back(mk("seg_t_route",   0,1,0,1,0,0,0,0, 3,1, 72'h01_00_00_01_01_00_03_00_00));
    vq.push_back(mk("both_buttons",  0,1,0,1,1,0,0,0, 2,1, 72'h01_00_00_01_01_00_03_00_00));
    vq.push_back(mk("reset_prio",    1,1,1,1,0,0,0,0, 1,1, RST_V));
    vq.push_back(mk("to_min",        0,1,1,0,0,1,0,0, 1,0, RST_V));
    vq.push_back(mk("min_dec_wrap",  0,1,1,0,1,0,0,0, 1,1, 72'h00_59_00_01_01_00_00_00_00));
    vq.push_back(mk("min_dec",       0,1,1,0,1,0,0,0, 1,1, 72'h00_58_00_01_01_00_00_00_00));
    vq.push_back(mk("move_and_step", 0,1,1,0,1,1,0,0, 1,1, 72'h00_57_00_01_01_00_00_00_00));
    vq.push_back(mk("h12_first",     0,1,1,1,0,0,0,1, 1,1, 72'h00_57_01_01_01_00_00_00_00));
    vq.push_back(mk("h12_max",       0,1,1,1,0,0,0,1,11,1, 72'h00_57_12_01_01_00_00_00_00));
    vq.push_back(mk("h12_wrap",      0,1,1,1,0,0,0,1, 1,1, 72'h00_57_01_01_01_00_00_00_00));
    vq.push_back(mk("h24_dec_wrap",  0,1,1,0,1,0,0,0, 2,1, 72'h00_57_23_01_01_00_00_00_00));
    vq.push_back(mk("h24_inc_wrap",  0,1,1,1,0,0,0,0, 1,1, 72'h00_57_00_01_01_00_00_00_00));
    vq.push_back(mk("h12_dec_from0", 0,1,1,0,1,0,0,1, 1,1, 72'h00_57_12_01_01_00_00_00_00));
    vq.push_back(mk("fmt_no_fix",    0,1,1,0,0,0,0,0, 2,1, 72'h00_57_12_01_01_00_00_00_00));
    vq.push_back(mk("h24_inc",       0,1,1,1,0,0,0,0, 1,1, 72'h00_57_13_01_01_00_00_00_00));
    vq.push_back(mk("h12_from13",    0,1,1,1,0,0,0,1, 1,1, 72'h00_57_01_01_01_00_00_00_00));
    vq.push_back(mk("reset2",        1,0,1,0,0,0,0,0, 1,1, RST_V));
    vq.push_back(mk("der_a1",        0,1,0,0,0,1,0,0, 1,0, RST_V));
    vq.push_back(mk("der_a0",        0,1,0,0,0,0,0,0, 1,0, RST_V));
    vq.push_back(mk("der_b1",        0,1,0,0,0,1,0,0, 1,0, RST_V));
    vq.push_back(mk("der_b0",        0,1,0,0,0,0,0,0, 1,0, RST_V));
    vq.push_back(mk("der_c1",        0,1,0,0,0,1,0,0, 1,0, RST_V));
    vq.push_back(mk("der_c0",        0,1,0,0,0,0,0,0, 1,0, RST_V));
    vq.push_back(mk("dia_wrap",      0,1,0,1,0,0,0,0,31,1, RST_V));
    vq.push_back(mk("dia_bcd_carry", 0,1,0,1,0,0,0,0, 9,1, 72'h00_00_00_10_01_00_00_00_00));
    vq.push_back(mk("dia_borrow",    0,1,0,0,1,0,0,0, 1,1, 72'h00_00_00_09_01_00_00_00_00));
    vq.push_back(mk("to_mes",        0,1,0,0,0,1,0,0, 1,0, 72'h00_00_00_09_01_00_00_00_00));
    vq.push_back(mk("mes_wrap",      0,1,0,0,1,0,0,0, 1,1, 72'h00_00_00_09_12_00_00_00_00));
    vq.push_back(mk("to_ano",        0,1,0,0,0,1,0,0, 1,0, 72'h00_00_00_09_12_00_00_00_00));
    vq.push_back(mk("ano_wrap",      0,1,0,0,1,0,0,0, 1,1, 72'h00_00_00_09_12_99_00_00_00));
    vq.push_back(mk("ano_to_seg",    0,1,0,0,0,1,0,0, 1,0, 72'h00_00_00_09_12_99_00_00_00));
    vq.push_back(mk("ptr_wrap_r",    0,1,0,1,0,0,0,0, 1,1, 72'h00_00_00_09_12_99_01_00_00));
    vq.push_back(mk("seg_to_ano",    0,1,0,0,0,0,1,0, 1,0, 72'h00_00_00_09_12_99_01_00_00));
    vq.push_back(mk("ptr_wrap_l",    0,1,0,1,0,0,0,0, 1,1, 72'h00_00_00_09_12_00_01_00_00));
    vq.push_back(mk("both_edges",    0,1,0,0,0,1,1,0, 1,0, 72'h00_00_00_09_12_00_01_00_00));
    vq.push_back(mk("stay_on_ano",   0,1,0,1,0,0,0,0, 1,1, 72'h00_00_00_09_12_01_01_00_00));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].esc, vq[i].ct, vq[i].up, vq[i].dn,
            vq[i].der, vq[i].izq, vq[i].doce, vq[i].reps);
      if (vq[i].chk) check(vq[i].name, vq[i].exp);
    end

    // Write disabled: buttons and pointer pulses must have no effect.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0, (k % 2) == 0, 0, 0, 1);
    end
    check("wr_off_hold", 72'h00_00_00_09_12_01_01_00_00);

    // A long corre_der hold moves once: ANO -> SEG, not further.
    drive(0, 1, 0, 0, 0, 1, 0, 0, 5);
    check("held_der_nostep", 72'h00_00_00_09_12_01_01_00_00);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0, 0, 0, 0, 1);
    check("held_der_once", 72'h00_00_00_09_12_01_02_00_00);

    // Timer hour range on HORA with C_T=0.
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1, 0, 0, 1, 1);
    check("hora_t_wrap", 72'h00_00_00_09_12_01_02_00_23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
